rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (we/waddr/wdata) among NUM_REQ writeback requesters: ALU, load unit, mul/div unit.
- Fixed priority with anti-starvation aging. Valid/ready handshake on each requester side.
- Registered write command to the register file, one cycle after acceptance.
- Sits between the writeback sources and the register file's synchronous write port.

Parameters:
- NUM_REQ, 3: number of requesters; index 0 has the highest base priority.
- XLEN, 32: data width.
- AW, 5: register address width.
- STARVE_LIMIT, 4: consecutive cycles a requester may wait (valid && !ready) before promotion; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- hold  in  1  pipeline stall; while high, no nonzero-address request is granted.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*AW  packed destination register per requester; slice i is [i*AW +: AW].
- req_data  in  NUM_REQ*XLEN  packed write data per requester; slice i is [i*XLEN +: XLEN].
- req_ready  out  NUM_REQ  per-requester accept, combinational.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  AW  register-file write address, registered.
- rf_wdata  out  XLEN  register-file write data, registered.
- starved  out  NUM_REQ  registered; bit i high while age[i] >= STARVE_LIMIT.

Behaviour:
- Reset (async, while rst=1):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - All age counters 0; starved=0.
  - req_ready forced to 0 combinationally while rst=1.
- Handshake:
  - A transfer occurs on a rising edge where req_valid[i] && req_ready[i].
  - A requester must hold valid, addr and data stable until it transfers.
  - Deasserting valid before a transfer is allowed (request withdrawn); its age clears.
- Zero-register requests (req_addr slice == 0):
  - req_ready[i]=1 whenever valid, regardless of hold or other requesters.
  - They never consume the port and never produce rf_we.
  - Age stays 0.
- Eligible set: requesters with valid=1 and nonzero address, gated by !hold.
- Grant selection, at most one per cycle, combinational:
  - If any eligible requester has age >= STARVE_LIMIT, grant the lowest-index such requester.
  - Otherwise grant the lowest-index eligible requester.
  - req_ready[g]=1 for the grantee only, plus the zero-address rule above.
- Write command latency: 1 cycle.
  - On the edge after a grant: rf_we=1, rf_waddr=addr_g, rf_wdata=data_g.
  - With no grant that cycle, rf_we=0, and rf_waddr/rf_wdata hold their previous values.
  - The register file writes on the following edge.
  - Sustained throughput is one write per cycle.
- Age counters, 4-bit, per requester, updated each edge:
  - Cleared on grant, when valid=0, or when the address is zero.
  - Incremented (saturating at 15) when the requester is eligible-but-not-granted, or is valid with nonzero address while hold=1.
- starved[i] is registered: bit i equals (age[i] >= STARVE_LIMIT) after each update.
- hold=1: no port grants; rf_we goes 0 on the next edge; ages keep counting.
- Reset mid-operation:
  - The pending write command is discarded (rf_we=0 immediately).
  - An accepted-but-not-yet-written transfer is lost; sources re-issue after reset.
- Same destination from two requesters in one cycle:
  - Arbitration alone decides; the loser writes later and its value is the final one.
  - No hazard merging.

Decomposition:
- Shared package `rf_pkg`:
  - Constants XLEN=32, AW=5, REG_ZERO=5'd0.
  - Requester index constants: REQ_ALU=0, REQ_LSU=1, REQ_MDU=2.
  - A typedef for the write command {we, addr, data}.
- One natural sub-module, `prio_age_picker`:
  - Inputs: eligible vector and per-requester starve flags.
  - Output: one-hot grant.
  - Pure combinational: lowest-index starved requester, else lowest-index eligible.

Test Plan:
- Reset: assert rst mid-stream while rf_we=1 -> rf_we=0, rf_waddr=0, req_ready=0 immediately; all outputs hold 0 until rst falls.
- Priority: req0 (x5, 0xAAAA0000) and req1 (x6, 0x11110000) valid together -> req_ready=3'b001; next edge rf_we=1, rf_waddr=5, rf_wdata=0xAAAA0000; one cycle later rf_waddr=6, rf_wdata=0x11110000.
- Starvation: req0 issues back-to-back writes every cycle while req2 (x9, 0xDEADBEEF) waits.
  - After 4 losing cycles starved[2]=1.
  - Next cycle req_ready=3'b100 -> rf_waddr=9, rf_wdata=0xDEADBEEF.
  - Age[2] then clears and starved[2]=0.
- x0 drop: req1 addr=0, data=0x12345678, together with req0 addr=x3 -> req_ready=3'b011 same cycle; only one write follows, with rf_waddr=3; no write to address 0 ever appears.
- hold: hold=1 for 3 cycles with req1 valid (x7) -> req_ready[1]=0 and rf_we=0 throughout; hold falls -> grant req1 in that cycle; write of x7 appears one edge later.
- Withdrawal: req2 valid 2 cycles without grant, then deasserted -> age[2] returns to 0; no write for req2 appears.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_pkg: shared writeback constants and write-command type
package rf_pkg;
  localparam int XLEN = 32;
  localparam int AW = 5;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;
  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_cmd_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback requester bundle plus the register-file write port
interface rf_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int XLEN = rf_pkg::XLEN,
  parameter int AW = rf_pkg::AW
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*AW-1:0]   req_addr;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rf_we;
  logic [AW-1:0]           rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  modport master (output req_valid, req_addr, req_data, input req_ready, rf_we, rf_waddr, rf_wdata);
  modport slave (input req_valid, req_addr, req_data, output req_ready, rf_we, rf_waddr, rf_wdata);
endinterface

// File: rtl/rf_wb_arbiter_picker.sv
// prio_age_picker: one-hot grant, lowest-index starved requester first, else lowest-index eligible
module prio_age_picker #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_elig,
  input  logic [N-1:0] i_starve,
  output logic [N-1:0] o_grant
);
  logic [N-1:0] w_pool;
  assign w_pool = |(i_elig & i_starve) ? (i_elig & i_starve) : i_elig;
  assign o_grant = w_pool & (~w_pool + N'(1));
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port among writeback sources with aging priority
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN = rf_pkg::XLEN,
  parameter int AW = rf_pkg::AW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  rf_wb_arbiter_if.slave     bus,
  output logic [NUM_REQ-1:0] starved
);
  logic [NUM_REQ-1:0] w_nz, w_elig, w_grant;
  logic [3:0]         r_age [NUM_REQ];
  logic [3:0]         w_age_nxt [NUM_REQ];
  logic [AW-1:0]      w_sel_addr, r_waddr;
  logic [XLEN-1:0]    w_sel_data, r_wdata;
  logic               r_we;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_nz
    assign w_nz[i] = |bus.req_addr[i*AW +: AW];
  end
  assign w_elig = bus.req_valid & w_nz & {NUM_REQ{!hold}};
  prio_age_picker #(.N(NUM_REQ)) u_pick (
    .i_elig   (w_elig),
    .i_starve (starved),
    .o_grant  (w_grant)
  );
  // x0 writes are discarded, so they are accepted at once without using the port
  assign bus.req_ready = rst ? '0 : (w_grant | (bus.req_valid & ~w_nz));
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = bus.req_addr[i*AW +: AW];
        w_sel_data = bus.req_data[i*XLEN +: XLEN];
      end
      w_age_nxt[i] = (!bus.req_valid[i] || !w_nz[i] || w_grant[i]) ? 4'd0 :
                     (r_age[i] == 4'hf) ? r_age[i] : r_age[i] + 4'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      starved <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_age[i] <= 4'd0;
    end else begin
      r_we <= |w_grant;
      if (|w_grant) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        r_age[i]   <= w_age_nxt[i];
        starved[i] <= w_age_nxt[i] >= 4'(STARVE_LIMIT);
      end
    end
  end
  assign bus.rf_we    = r_we;
  assign bus.rf_waddr = r_waddr;
  assign bus.rf_wdata = r_wdata;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench with a rule-level arbitration model
module tb_rf_wb_arbiter;
  import rf_pkg::*;
  localparam int N = 3;
  localparam int LIM = 4;
  typedef struct {
    logic [N-1:0] rdy;
    logic [N-1:0] stv;
  } chk_t;
  logic clk = 0, rst = 1, hold = 0;
  logic [N-1:0] starved;
  rf_wb_arbiter_if #(.NUM_REQ(N), .XLEN(XLEN), .AW(AW)) bus ();
  rf_wb_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .AW(AW), .STARVE_LIMIT(LIM)) dut (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold),
    .bus     (bus),
    .starved (starved)
  );
  always #5 clk = ~clk;
  wr_cmd_t rf_q[$];
  chk_t chk_q[$];
  int age[N];
  logic [N-1:0] last_rdy = '0;
  int n_chk = 0, n_fail = 0;
  logic [AW-1:0] last_addr = '0;
  logic [XLEN-1:0] last_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*AW-1:0] pk_a(input logic [AW-1:0] a2, a1, a0);
    return {a2, a1, a0};
  endfunction

  function automatic logic [N*XLEN-1:0] pk_d(input logic [XLEN-1:0] d2, d1, d0);
    return {d2, d1, d0};
  endfunction

  // Reference: zero-address requests always accepted; among nonzero requests (not held),
  // the first one aged past the limit wins, otherwise the first one wins.
  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N*XLEN-1:0] d, input logic h);
    chk_t c;
    wr_cmd_t w;
    logic [N-1:0] rdy;
    int g;
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_addr = a;
    bus.req_data = d;
    hold = h;
    rdy = '0;
    g = -1;
    for (int i = 0; i < N; i++) begin
      c.stv[i] = age[i] >= LIM;
      if (v[i] && a[i*AW +: AW] == REG_ZERO) rdy[i] = 1'b1;
      if (g < 0 && v[i] && a[i*AW +: AW] != REG_ZERO && !h && age[i] >= LIM) g = i;
    end
    for (int i = 0; i < N; i++)
      if (g < 0 && v[i] && a[i*AW +: AW] != REG_ZERO && !h) g = i;
    if (g >= 0) begin
      rdy[g] = 1'b1;
      w.we = 1'b1;
      w.addr = a[g*AW +: AW];
      w.data = d[g*XLEN +: XLEN];
      rf_q.push_back(w);
    end
    c.rdy = rdy;
    chk_q.push_back(c);
    for (int i = 0; i < N; i++)
      age[i] = (!v[i] || a[i*AW +: AW] == REG_ZERO || i == g) ? 0 : (age[i] < 15 ? age[i] + 1 : 15);
    last_rdy = rdy;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1;
    rf_q.delete();
    for (int i = 0; i < N; i++) age[i] = 0;
    last_rdy = '0;
    repeat (n) @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    hold = 0;
    rst = 0;
  endtask

  initial forever begin
    chk_t c;
    wr_cmd_t w;
    @(negedge clk);
    if (rst) begin
      check("rst_we", bus.rf_we, 0);
      check("rst_waddr", bus.rf_waddr, 0);
      check("rst_wdata", bus.rf_wdata, 0);
      check("rst_ready", bus.req_ready, 0);
      check("rst_starved", starved, 0);
      last_addr = '0;
      last_data = '0;
    end else begin
      if (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        check("req_ready", bus.req_ready, c.rdy);
        check("starved", starved, c.stv);
      end
      if (bus.rf_we) begin
        check("waddr_nonzero", bus.rf_waddr != REG_ZERO, 1);
        check("write_expected", rf_q.size() > 0, 1);
        if (rf_q.size() > 0) begin
          w = rf_q.pop_front();
          check("rf_waddr", bus.rf_waddr, w.addr);
          check("rf_wdata", bus.rf_wdata, w.data);
        end
        last_addr = bus.rf_waddr;
        last_data = bus.rf_wdata;
      end else begin
        check("waddr_hold", bus.rf_waddr, last_addr);
        check("wdata_hold", bus.rf_wdata, last_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] v;
    logic [N*AW-1:0] a;
    logic [N*XLEN-1:0] d;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    // fixed priority
    step(3'b011, pk_a(0, 6, 5), pk_d(0, 32'h11110000, 32'hAAAA0000), 0);
    step(3'b010, pk_a(0, 6, 0), pk_d(0, 32'h11110000, 0), 0);
    step(3'b000, '0, '0, 0);
    // starvation of the MDU behind back-to-back ALU writes
    for (int k = 0; k < 5; k++)
      step(3'b101, pk_a(9, 0, AW'(k + 1)), pk_d(32'hDEADBEEF, 0, XLEN'(k)), 0);
    step(3'b001, pk_a(0, 0, 5), pk_d(0, 0, 4), 0);
    step(3'b000, '0, '0, 0);
    // x0 request accepted alongside a real write
    step(3'b011, pk_a(0, 0, 3), pk_d(0, 32'h12345678, 32'h33333333), 0);
    step(3'b000, '0, '0, 0);
    // hold stalls the port
    repeat (3) step(3'b010, pk_a(0, 7, 0), pk_d(0, 32'h77777777, 0), 1);
    step(3'b010, pk_a(0, 7, 0), pk_d(0, 32'h77777777, 0), 0);
    step(3'b000, '0, '0, 0);
    // withdrawal clears age, so the reissued request does not starve early
    step(3'b101, pk_a(4, 0, 1), pk_d(32'h44444444, 0, 1), 0);
    step(3'b101, pk_a(4, 0, 2), pk_d(32'h44444444, 0, 2), 0);
    step(3'b001, pk_a(0, 0, 3), pk_d(0, 0, 3), 0);
    for (int k = 0; k < 4; k++)
      step(3'b101, pk_a(8, 0, AW'(k + 10)), pk_d(32'h88888888, 0, XLEN'(k + 100)), 0);
    step(3'b100, pk_a(8, 0, 0), pk_d(32'h88888888, 0, 0), 0);
    step(3'b000, '0, '0, 0);
    // reset while a write is on the port
    step(3'b011, pk_a(0, 0, 10), pk_d(0, 32'h5555, 32'hA0A0), 0);
    do_reset(2);
    v = '0;
    a = '0;
    d = '0;
    repeat (500) begin
      for (int i = 0; i < N; i++) begin
        if (v[i] && last_rdy[i]) v[i] = 1'b0;
        else if (v[i] && $urandom_range(0, 15) == 0) v[i] = 1'b0;
        else if (!v[i] && $urandom_range(0, 2) != 0) begin
          v[i] = 1'b1;
          a[i*AW +: AW] = ($urandom_range(0, 4) == 0) ? REG_ZERO : AW'($urandom_range(1, 31));
          d[i*XLEN +: XLEN] = $urandom;
        end
      end
      step(v, a, d, $urandom_range(0, 5) == 0);
    end
    step(3'b000, '0, '0, 0);
    step(3'b000, '0, '0, 0);
    @(negedge clk);
    #1;
    check("drain_writes", rf_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
